shared_reg_arbiter: RTL and testbench

Round-robin controller that shares one WIDTH-bit register (a bank of sync set/clear D flops) between NREQ requesters. Each requester asks for the register with a req/gnt handshake and a command (write, clear, set, no-op). The winning command is latched and committed to the register; the register value is broadcast to all requesters. It sits between client blocks and the shared flop bank in the Week-1 flop library, so no two clients can drive d/set/rst in the same cycle.

---
 rtl/shared_reg_arbiter_pkg.sv | 17 +
 rtl/shared_reg_arbiter_rr_pick.sv | 30 +++
 rtl/shared_reg_arbiter.sv | 103 ++++++++++
 tb/tb_shared_reg_arbiter.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/shared_reg_arbiter_pkg.sv
// Shared definitions for the shared register arbiter:
// command encodings and FSM state encoding.
package shared_reg_arbiter_pkg;

   typedef enum logic [1:0] {
      OP_WRITE = 2'b00,
      OP_CLEAR = 2'b01,
      OP_SET   = 2'b10,
      OP_NOP   = 2'b11
   } op_e;

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_APPLY = 1'b1
   } state_e;

endpackage

// File: rtl/shared_reg_arbiter_rr_pick.sv
// Combinational round-robin pick: first asserted request
// at or after the pointer, scanning upward with wrap.
module rr_pick #(
   parameter int NREQ = 4,
   parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic [NREQ-1:0] i_req,
   input  logic [IW-1:0]   i_ptr,
   output logic [IW-1:0]   o_win,
   output logic            o_valid
);

   int w_idx;

   // Scan from the farthest offset down so the nearest hit wins
   always_comb begin
      o_valid = 1'b0;
      o_win   = '0;
      w_idx   = 0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         w_idx = int'(i_ptr) + k;
         if (w_idx >= NREQ) w_idx = w_idx - NREQ;
         if (i_req[w_idx]) begin
            o_valid = 1'b1;
            o_win   = IW'(w_idx);
         end
      end
   end

endmodule

// File: rtl/shared_reg_arbiter.sv
// Round-robin owner of one shared WIDTH-bit register: one
// command is granted, latched and committed per two cycles.
module shared_reg_arbiter
   import shared_reg_arbiter_pkg::*;
#(
   parameter int              NREQ      = 4,
   parameter int              WIDTH     = 8,
   parameter logic [WIDTH-1:0] RESET_VAL = '0,
   localparam int             IW        = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NREQ-1:0]       req,
   input  logic [2*NREQ-1:0]     op,
   input  logic [WIDTH*NREQ-1:0] wdata,
   output logic [NREQ-1:0]       gnt,
   output logic [WIDTH-1:0]      q,
   output logic                  busy,
   output logic [IW-1:0]         owner
);

   state_e           r_state;
   op_e              r_op;
   logic [WIDTH-1:0] r_data;
   logic [WIDTH-1:0] r_q;
   logic [NREQ-1:0]  r_gnt;
   logic             r_busy;
   logic [IW-1:0]    r_owner;
   logic [IW-1:0]    r_ptr;

   logic [IW-1:0]    w_win;
   logic             w_valid;
   logic [IW-1:0]    w_ptr_next;

   rr_pick #(
      .NREQ (NREQ),
      .IW   (IW)
   ) u_pick (
      .i_req   (req),
      .i_ptr   (r_ptr),
      .o_win   (w_win),
      .o_valid (w_valid)
   );

   // Pointer moves one past the winner, wrapping at NREQ-1
   always_comb begin
      w_ptr_next = r_owner + 1'b1;
      if (r_owner == IW'(NREQ - 1)) w_ptr_next = '0;
   end

   // Two-state FSM: grant/latch in IDLE, commit in APPLY
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_op    <= OP_WRITE;
         r_data  <= '0;
         r_gnt   <= '0;
         r_busy  <= 1'b0;
         r_owner <= '0;
         r_ptr   <= '0;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               if (w_valid) begin
                  r_op         <= op_e'(op[2*int'(w_win) +: 2]);
                  r_data       <= wdata[WIDTH*int'(w_win) +: WIDTH];
                  r_gnt        <= '0;
                  r_gnt[w_win] <= 1'b1;
                  r_owner      <= w_win;
                  r_busy       <= 1'b1;
                  r_state      <= S_APPLY;
               end
            end
            S_APPLY: begin
               r_gnt   <= '0;
               r_busy  <= 1'b0;
               r_ptr   <= w_ptr_next;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   // Commit the latched command to the shared flops in APPLY
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_q <= RESET_VAL;
      end else if (r_state == S_APPLY) begin
         unique case (r_op)
            OP_WRITE: r_q <= r_data;
            OP_CLEAR: r_q <= '0;
            OP_SET:   r_q <= '1;
            OP_NOP:   r_q <= r_q;
         endcase
      end
   end

   assign gnt   = r_gnt;
   assign q     = r_q;
   assign busy  = r_busy;
   assign owner = r_owner;

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Bench for shared_reg_arbiter: transaction-level model plus
// directed scenarios with literal expectations.
module tb_shared_reg_arbiter;

   localparam int NREQ = 4;
   localparam int W    = 8;
   localparam logic [W-1:0] RV = 8'hA5;

   logic            clk = 1'b0;
   logic            rst;
   logic [NREQ-1:0] req   = '0;
   logic [2*NREQ-1:0] op  = '1;
   logic [W*NREQ-1:0] wdata = '0;
   logic [NREQ-1:0] gnt;
   logic [W-1:0]    q;
   logic            busy;
   logic [1:0]      owner;

   int n_pass = 0;
   int n_tot  = 0;

   shared_reg_arbiter #(
      .NREQ      (NREQ),
      .WIDTH     (W),
      .RESET_VAL (RV)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .req   (req),
      .op    (op),
      .wdata (wdata),
      .gnt   (gnt),
      .q     (q),
      .busy  (busy),
      .owner (owner)
   );

   always #5 clk = ~clk;

   // Model: a pending transaction (or none), a pointer, a value
   bit         m_pend = 0;
   int         m_win  = 0;
   int         m_ptr  = 0;
   int         m_own  = 0;
   logic [1:0] m_op   = 2'b00;
   logic [W-1:0] m_d  = '0;
   logic [W-1:0] m_q  = RV;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_pend = 0; m_ptr = 0; m_own = 0; m_q = RV;
      end else if (m_pend) begin
         case (m_op)
            2'b00: m_q = m_d;
            2'b01: m_q = '0;
            2'b10: m_q = '1;
            default: ;
         endcase
         m_ptr  = (m_win + 1) % NREQ;
         m_pend = 0;
      end else if (req != 0) begin
         for (int k = 0; k < NREQ; k++) begin
            if (!m_pend && req[(m_ptr + k) % NREQ]) begin
               m_win  = (m_ptr + k) % NREQ;
               m_op   = op[2*m_win +: 2];
               m_d    = wdata[W*m_win +: W];
               m_own  = m_win;
               m_pend = 1;
            end
         end
      end
   end

   task automatic chk(input string nm, input int act, input int exp);
      n_tot++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   // Every cycle: outputs must match the model
   always @(negedge clk) begin
      if (rst !== 1'bx) begin
         chk("m_gnt", int'(gnt), m_pend ? (1 << m_win) : 0);
         chk("m_busy", int'(busy), int'(m_pend));
         chk("m_q", int'(q), int'(m_q));
         chk("m_owner", int'(owner), m_own);
         chk("m_onehot", int'($countones(gnt) <= 1), 1);
      end
   end

   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic setop(input int i, input logic [1:0] o,
                        input logic [W-1:0] d);
      op[2*i +: 2]  = o;
      wdata[W*i +: W] = d;
   endtask

   logic [W-1:0] fd [NREQ];

   initial begin
      rst = 1'b1;
      tick(3);
      rst = 1'b0;
      chk("rst_q", int'(q), 'hA5);
      chk("rst_gnt", int'(gnt), 0);
      tick(2);

      // Single write from requester 0
      setop(0, 2'b00, 8'h3C);
      req = 4'b0001;
      tick();
      req = '0;
      chk("wr_gnt", int'(gnt), 1);
      chk("wr_busy", int'(busy), 1);
      chk("wr_owner", int'(owner), 0);
      tick();
      chk("wr_q", int'(q), 'h3C);
      chk("wr_gnt_off", int'(gnt), 0);

      // Set then clear from requester 2
      setop(2, 2'b10, 8'h00);
      req = 4'b0100;
      tick();
      req = '0;
      chk("set_gnt", int'(gnt), 4);
      tick();
      chk("set_q", int'(q), 'hFF);
      setop(2, 2'b01, 8'h00);
      req = 4'b0100;
      tick();
      req = '0;
      tick();
      chk("clr_q", int'(q), 0);

      // No-op from 3 wraps the pointer to 0 and leaves q
      setop(3, 2'b11, 8'hEE);
      req = 4'b1000;
      tick();
      req = '0;
      tick();
      chk("nop_q", int'(q), 0);

      // Fairness with all requests held
      fd[0] = 8'h11; fd[1] = 8'h22; fd[2] = 8'h33; fd[3] = 8'h44;
      for (int i = 0; i < NREQ; i++) setop(i, 2'b00, fd[i]);
      req = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         tick();
         chk("fair_gnt", int'(gnt), 1 << (k % NREQ));
         tick();
         chk("fair_q", int'(q), int'(fd[k % NREQ]));
      end
      req = '0;
      tick();

      // Withdrawal in the grant cycle still commits
      setop(1, 2'b00, 8'h5A);
      req = 4'b0010;
      tick();
      chk("wd_gnt", int'(gnt), 2);
      req = '0;
      tick();
      chk("wd_q", int'(q), 'h5A);

      // Request raised and dropped while busy is never granted
      setop(0, 2'b00, 8'h66);
      setop(3, 2'b00, 8'h99);
      req = 4'b0001;
      tick();
      req = 4'b1000;
      #2;
      req = '0;
      tick(3);
      chk("busy_q", int'(q), 'h66);
      chk("busy_gnt", int'(gnt), 0);

      // Reset during APPLY discards the pending write
      setop(0, 2'b00, 8'h77);
      req = 4'b0001;
      tick();
      req = '0;
      chk("mid_busy", int'(busy), 1);
      #1;
      rst = 1'b1;
      #1;
      chk("mid_q", int'(q), 'hA5);
      chk("mid_gnt", int'(gnt), 0);
      chk("mid_bsy0", int'(busy), 0);
      rst = 1'b0;
      setop(1, 2'b00, 8'h12);
      setop(2, 2'b00, 8'h34);
      req = 4'b0110;
      tick();
      req = '0;
      chk("post_gnt", int'(gnt), 2);
      tick();
      chk("post_q", int'(q), 'h12);
      tick(2);

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
